diff_scan_unit: RTL and testbench

DIFF_SCAN_UNIT -- requirements
Module: diff_scan_unit

---
 rtl/diff_scan_unit.sv | 119 +++++++++++
 tb/tb_diff_scan_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/diff_scan_unit.sv
// Chunk-serial scanner that reports the 1-based position of the least- or
// most-significant bit at which two operands differ, one CHUNK per clock.
module diff_scan_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       mode,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       busy,
  output logic                       done,
  output logic                       found,
  output logic [$clog2(WIDTH+1)-1:0] result
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = $clog2(WIDTH + 1);
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       r_state;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_x;
  logic             r_mode;
  logic             r_found;
  logic [IDXW-1:0]  r_result;

  logic [CHUNK-1:0] w_chunk;
  logic [IDXW-1:0]  w_base;
  logic [IDXW-1:0]  w_off;
  logic [IDXW-1:0]  w_pos;
  logic             w_nz;
  logic             w_last;

  // Mode 0 walks chunks upward from bit 0, mode 1 walks downward from the MSB.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_chunk = '0;
    w_base  = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      if (r_k == KW'(c)) begin
        if (r_mode) begin
          w_chunk = r_x[WIDTH-1-c*CHUNK -: CHUNK];
          w_base  = IDXW'(WIDTH - CHUNK - c*CHUNK);
        end else begin
          w_chunk = r_x[c*CHUNK +: CHUNK];
          w_base  = IDXW'(c*CHUNK);
        end
      end
    end
  end

  // Loop order decides which set bit wins: last assignment is kept.
  always_comb begin
    w_off = '0;
    if (r_mode) begin
      for (int j = 0; j < CHUNK; j++)
        if (w_chunk[j]) w_off = IDXW'(j);
    end else begin
      for (int j = CHUNK - 1; j >= 0; j--)
        if (w_chunk[j]) w_off = IDXW'(j);
    end
  end

  assign w_nz   = |w_chunk;
  assign w_last = (r_k == KW'(NCHUNK - 1));
  assign w_pos  = w_base + w_off + IDXW'(1);

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_k      <= '0;
      r_x      <= '0;
      r_mode   <= 1'b0;
      r_found  <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_x     <= a ^ b;
            r_mode  <= mode;
            r_k     <= '0;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (w_nz) begin
            r_result <= w_pos;
            r_found  <= 1'b1;
            r_state  <= DONE;
          end else if (w_last) begin
            r_result <= '0;
            r_found  <= 1'b0;
            r_state  <= DONE;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy   = (r_state == SCAN);
  assign done   = (r_state == DONE);
  assign found  = r_found;
  assign result = r_result;

endmodule

// File: tb/tb_diff_scan_unit.sv
// Directed bench for diff_scan_unit (WIDTH=32, CHUNK=8): vector table plus
// hand-written sequences for overlapping start and mid-scan reset.
module tb_diff_scan_unit;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int IDXW  = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            mode;
  logic [31:0]     a;
  logic [31:0]     b;
  logic            busy;
  logic            done;
  logic            found;
  logic [IDXW-1:0] result;

  int total = 0;
  int bad   = 0;

  diff_scan_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy), .done(done), .found(found), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [31:0] a;
    logic [31:0] b;
    int          exp_result;
    logic        exp_found;
    int          exp_edges;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a start at edge 0 and return the edge index at which done is seen.
  task automatic launch(input logic m, input logic [31:0] va, input logic [31:0] vb,
                        output int edges);
    a = va; b = vb; mode = m; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~va; b = 32'h1234_5678; mode = ~m;
    edges = 99;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (done) begin
        edges = e;
        break;
      end
    end
  endtask

  initial begin
    int edges;
    int pulses;

    vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0000_0001,  1, 1'b1, 1};
    vecs[1]  = '{1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF,  0, 1'b0, 4};
    vecs[2]  = '{1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF,  0, 1'b0, 4};
    vecs[3]  = '{1'b0, 32'h8000_0000, 32'h0000_0000, 32, 1'b1, 4};
    vecs[4]  = '{1'b1, 32'h8000_0000, 32'h0000_0000, 32, 1'b1, 1};
    vecs[5]  = '{1'b0, 32'h0001_0100, 32'h0000_0000,  9, 1'b1, 2};
    vecs[6]  = '{1'b1, 32'h0001_0100, 32'h0000_0000, 17, 1'b1, 2};
    vecs[7]  = '{1'b0, 32'hF000_0000, 32'h0F00_0000, 25, 1'b1, 4};
    vecs[8]  = '{1'b1, 32'hF000_0000, 32'h0F00_0000, 32, 1'b1, 1};
    vecs[9]  = '{1'b1, 32'h0000_0081, 32'h0000_0000,  8, 1'b1, 4};
    vecs[10] = '{1'b0, 32'h0000_0081, 32'h0000_0000,  1, 1'b1, 1};
    vecs[11] = '{1'b0, 32'h5555_0000, 32'h5554_0000, 17, 1'b1, 3};

    rst = 1'b1; start = 1'b1; mode = 1'b0; a = 32'h1; b = 32'h0;
    tick(); tick();
    check("reset_busy",   int'(busy),   0);
    check("reset_done",   int'(done),   0);
    check("reset_found",  int'(found),  0);
    check("reset_result", int'(result), 0);
    rst = 1'b0; start = 1'b0;

    for (int i = 0; i < 3; i++) tick();
    check("idle_hold_busy", int'(busy), 0);
    check("idle_hold_done", int'(done), 0);

    for (int i = 0; i < 12; i++) begin
      launch(vecs[i].mode, vecs[i].a, vecs[i].b, edges);
      check($sformatf("v%0d_latency", i), edges, vecs[i].exp_edges);
      check($sformatf("v%0d_result", i), int'(result), vecs[i].exp_result);
      check($sformatf("v%0d_found", i), int'(found), int'(vecs[i].exp_found));
      check($sformatf("v%0d_busy_in_done", i), int'(busy), 0);
      tick();
      check($sformatf("v%0d_done_one_cycle", i), int'(done), 0);
      tick();
      check($sformatf("v%0d_result_holds", i), int'(result), vecs[i].exp_result);
    end

    // Restart attempts and operand changes during SCAN must be ignored.
    a = 32'h0001_0100; b = 32'h0; mode = 1'b0; start = 1'b1;
    tick();
    a = 32'hFFFF_FFFF; b = 32'h0; mode = 1'b1;
    pulses = 0;
    edges  = 99;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 1) check("ovl_busy_e1", int'(busy), 1);
      if (e == 2) start = 1'b0;
      if (done) begin
        pulses++;
        if (edges == 99) begin
          edges = e;
          check("ovl_result", int'(result), 9);
          check("ovl_found",  int'(found),  1);
        end
      end
    end
    check("ovl_latency", edges, 2);
    check("ovl_pulses", pulses, 1);
    check("ovl_idle_busy", int'(busy), 0);

    // Reset at edge 2 of a full four-chunk scan aborts silently.
    a = 32'hCAFE_F00D; b = 32'hCAFE_F00D; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("abort_busy_before", int'(busy), 1);
    rst = 1'b1;
    tick();
    check("abort_busy",   int'(busy),   0);
    check("abort_result", int'(result), 0);
    check("abort_found",  int'(found),  0);
    check("abort_done",   int'(done),   0);
    rst = 1'b0;
    pulses = 0;
    for (int e = 0; e < 6; e++) begin
      tick();
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);

    // First start after reset is accepted normally.
    launch(1'b1, 32'h8000_0000, 32'h0, edges);
    check("post_rst_latency", edges, 1);
    check("post_rst_result", int'(result), 32);
    check("post_rst_found", int'(found), 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
